// File: rtl/membus_pkg.sv
// Shared types and widths for the PDP-6 memory bus arbiter.
package membus_pkg;

    localparam int MA_W  = 15;
    localparam int MB_W  = 36;
    localparam int SEL_W = 4;
    localparam int IDX_W = 2;   // port index width, enough for up to 4 masters

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONNECT,
        ST_NXM,
        ST_RELEASE
    } state_e;

    // Everything the arbiter forwards from the owning master to the slave.
    typedef struct packed {
        logic             rq_cyc;
        logic             rd_rq;
        logic             wr_rq;
        logic             wr_rs;
        logic [MA_W-1:0]  ma;
        logic [SEL_W-1:0] sel;
        logic             fmc_select;
        logic [MB_W-1:0]  mb_write;
    } slv_req_t;

    // One-hot (up to 4 ports) to binary port index.
    function automatic logic [IDX_W-1:0] oh_to_idx(input logic [3:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/membus_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the memory slave.
// The arbiter uses the slave modport; the environment (masters plus memory)
// uses the master modport.
interface membus_arbiter_if
    import membus_pkg::*;
#(
    parameter int NPORT = 3
);
    // master side
    logic [NPORT-1:0]             m_rq_cyc;
    logic [NPORT-1:0]             m_rd_rq;
    logic [NPORT-1:0]             m_wr_rq;
    logic [NPORT-1:0]             m_wr_rs;
    logic [NPORT-1:0][MA_W-1:0]   m_ma;
    logic [NPORT-1:0][SEL_W-1:0]  m_sel;
    logic [NPORT-1:0]             m_fmc_select;
    logic [NPORT-1:0][MB_W-1:0]   m_mb_write;
    logic [NPORT-1:0]             m_addr_ack;
    logic [NPORT-1:0]             m_rd_rs;
    logic [MB_W-1:0]              m_mb_read;
    logic [NPORT-1:0]             m_nxm;
    logic [NPORT-1:0]             grant;

    // memory slave side
    logic                         s_rq_cyc;
    logic                         s_rd_rq;
    logic                         s_wr_rq;
    logic                         s_wr_rs;
    logic [MA_W-1:0]              s_ma;
    logic [SEL_W-1:0]             s_sel;
    logic                         s_fmc_select;
    logic [MB_W-1:0]              s_mb_write;
    logic                         s_addr_ack;
    logic                         s_rd_rs;
    logic [MB_W-1:0]              s_mb_read;

    modport slave (
        input  m_rq_cyc, m_rd_rq, m_wr_rq, m_wr_rs, m_ma, m_sel, m_fmc_select, m_mb_write,
        input  s_addr_ack, s_rd_rs, s_mb_read,
        output m_addr_ack, m_rd_rs, m_mb_read, m_nxm, grant,
        output s_rq_cyc, s_rd_rq, s_wr_rq, s_wr_rs, s_ma, s_sel, s_fmc_select, s_mb_write
    );

    modport master (
        output m_rq_cyc, m_rd_rq, m_wr_rq, m_wr_rs, m_ma, m_sel, m_fmc_select, m_mb_write,
        output s_addr_ack, s_rd_rs, s_mb_read,
        input  m_addr_ack, m_rd_rs, m_mb_read, m_nxm, grant,
        input  s_rq_cyc, s_rd_rq, s_wr_rq, s_wr_rs, s_ma, s_sel, s_fmc_select, s_mb_write
    );

endinterface

// File: rtl/membus_arbiter_rr_pick.sv
// Round-robin priority encoder: the first requester after `last` wins.
module rr_pick
    import membus_pkg::*;
#(
    parameter int NPORT = 3
) (
    input  logic [NPORT-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [NPORT-1:0] win
);

    // Scan from the farthest port to the nearest so the port just after
    // `last` overrides everything else; indices stay constant after unrolling.
    always_comb begin
        win = '0;
        for (int k = NPORT; k >= 1; k--) begin
            for (int i = 0; i < NPORT; i++) begin
                if (i == (int'(last) + k) % NPORT && req[i]) begin
                    win    = '0;
                    win[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/membus_arbiter.sv
// Shares one memory slave among NPORT masters. Grants round-robin, holds the
// grant for a whole memory cycle (including read-modify-write), registers the
// bus one stage in each direction and aborts cycles to nonexistent memory.
module membus_arbiter
    import membus_pkg::*;
#(
    parameter int NPORT   = 3,
    parameter int TIMEOUT = 1000
) (
    input  logic            clk,
    input  logic            reset_n,
    membus_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state;
    logic [NPORT-1:0]  grant_q;
    logic [NPORT-1:0]  win;
    logic [NPORT-1:0]  addr_ack_q;
    logic [NPORT-1:0]  rd_rs_q;
    logic [NPORT-1:0]  nxm_q;
    logic [MB_W-1:0]   mb_read_q;
    logic [IDX_W-1:0]  last;
    logic [CNT_W-1:0]  cnt;
    logic              acked;
    slv_req_t          fwd;
    slv_req_t          s_req_q;
    logic              owner_rq;
    logic              timed_out;

    rr_pick #(.NPORT(NPORT)) u_pick (
        .req  (bus.m_rq_cyc),
        .last (last),
        .win  (win)
    );

    // Select the owning master's request lines; zero when nobody owns the bus.
    always_comb begin
        fwd = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (grant_q[i]) begin
                fwd.rq_cyc     = bus.m_rq_cyc[i];
                fwd.rd_rq      = bus.m_rd_rq[i];
                fwd.wr_rq      = bus.m_wr_rq[i];
                fwd.wr_rs      = bus.m_wr_rs[i];
                fwd.ma         = bus.m_ma[i];
                fwd.sel        = bus.m_sel[i];
                fwd.fmc_select = bus.m_fmc_select[i];
                fwd.mb_write   = bus.m_mb_write[i];
            end
        end
    end

    assign owner_rq  = |(bus.m_rq_cyc & grant_q);
    assign timed_out = (cnt == CNT_W'(TIMEOUT));

    // Arbitration FSM with both register stages and the NXM timeout counter.
    // Register stages default to 0 each cycle; only CONNECT passes data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            last       <= IDX_W'(NPORT - 1);
            cnt        <= '0;
            acked      <= 1'b0;
            s_req_q    <= '0;
            addr_ack_q <= '0;
            rd_rs_q    <= '0;
            mb_read_q  <= '0;
            nxm_q      <= '0;
        end else begin
            s_req_q    <= '0;
            addr_ack_q <= '0;
            rd_rs_q    <= '0;
            mb_read_q  <= '0;
            nxm_q      <= '0;
            case (state)
                ST_IDLE: begin
                    cnt   <= '0;
                    acked <= 1'b0;
                    if (|bus.m_rq_cyc) begin
                        grant_q <= win;
                        state   <= ST_CONNECT;
                    end
                end
                ST_CONNECT: begin
                    addr_ack_q <= grant_q & {NPORT{bus.s_addr_ack}};
                    rd_rs_q    <= grant_q & {NPORT{bus.s_rd_rs}};
                    mb_read_q  <= bus.s_rd_rs ? bus.s_mb_read : '0;
                    // Counter freezes for good once the slave has acknowledged.
                    if (bus.s_addr_ack)
                        acked <= 1'b1;
                    else if (s_req_q.rq_cyc && !acked && !timed_out)
                        cnt <= cnt + CNT_W'(1);
                    if (!owner_rq && !bus.s_addr_ack) begin
                        state <= ST_RELEASE;
                    end else if (timed_out) begin
                        state      <= ST_NXM;
                        nxm_q      <= grant_q;
                        addr_ack_q <= '0;
                        rd_rs_q    <= '0;
                        mb_read_q  <= '0;
                    end else begin
                        s_req_q <= fwd;
                    end
                end
                ST_NXM: begin
                    if (!owner_rq) state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    last    <= oh_to_idx(4'(grant_q));
                    grant_q <= '0;
                    cnt     <= '0;
                    acked   <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant        = grant_q;
    assign bus.m_addr_ack   = addr_ack_q;
    assign bus.m_rd_rs      = rd_rs_q;
    assign bus.m_mb_read    = mb_read_q;
    assign bus.m_nxm        = nxm_q;
    assign bus.s_rq_cyc     = s_req_q.rq_cyc;
    assign bus.s_rd_rq      = s_req_q.rd_rq;
    assign bus.s_wr_rq      = s_req_q.wr_rq;
    assign bus.s_wr_rs      = s_req_q.wr_rs;
    assign bus.s_ma         = s_req_q.ma;
    assign bus.s_sel        = s_req_q.sel;
    assign bus.s_fmc_select = s_req_q.fmc_select;
    assign bus.s_mb_write   = s_req_q.mb_write;

endmodule
